// File: rtl/snake_game_ctrl.sv
// rtl/snake_game_ctrl.sv - snake game controller: head motion, prey placement, score and game FSM
module snake_game_ctrl #(
    parameter int STEP        = 10,
    parameter int MOVE_FRAMES = 6,
    parameter int X_MIN       = 15,
    parameter int X_MAX       = 620,
    parameter int Y_MIN       = 15,
    parameter int Y_MAX       = 455,
    parameter int HEAD        = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_start,
    output logic [9:0] head_x,
    output logic [9:0] head_y,
    output logic [9:0] prey_x,
    output logic [9:0] prey_y,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
    typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] XMIN_W = 11'(X_MIN);
    localparam logic [10:0] XMAX_W = 11'(X_MAX);
    localparam logic [10:0] YMIN_W = 11'(Y_MIN);
    localparam logic [10:0] YMAX_W = 11'(Y_MAX);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [9:0]  HEAD10 = 10'(HEAD);
    localparam logic [9:0]  XMIN10 = 10'(X_MIN);
    localparam logic [9:0]  YMIN10 = 10'(Y_MIN);
    localparam logic [7:0]  LAST_FRAME = 8'(MOVE_FRAMES - 1);

    state_t      state_q;
    dir_t        dir_q;
    dir_t        pend_q;
    logic [7:0]  frame_cnt;
    logic [15:0] lfsr;
    logic        start_q;
    logic        eat_due;

    logic        start_evt;
    logic        btn_one;
    dir_t        btn_dir;
    dir_t        dir_rev;
    logic        move_ok;
    logic [9:0]  nx;
    logic [9:0]  ny;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        hit;
    logic [10:0] hx_w;
    logic [10:0] hy_w;
    logic [9:0]  ly;
    logic [9:0]  new_prey_x;
    logic [9:0]  new_prey_y;

    assign start_evt = btn_start & ~start_q;
    assign hx_w      = {1'b0, head_x};
    assign hy_w      = {1'b0, head_y};
    assign state     = state_q;

    always_comb begin
        btn_one = 1'b0;
        btn_dir = DIR_RIGHT;
        case ({btn_up, btn_down, btn_left, btn_right})
            4'b1000: begin btn_one = 1'b1; btn_dir = DIR_UP;    end
            4'b0100: begin btn_one = 1'b1; btn_dir = DIR_DOWN;  end
            4'b0010: begin btn_one = 1'b1; btn_dir = DIR_LEFT;  end
            4'b0001: begin btn_one = 1'b1; btn_dir = DIR_RIGHT; end
            default: ;
        endcase
    end

    always_comb begin
        dir_rev = DIR_LEFT;
        case (dir_q)
            DIR_RIGHT: dir_rev = DIR_LEFT;
            DIR_LEFT:  dir_rev = DIR_RIGHT;
            DIR_UP:    dir_rev = DIR_DOWN;
            DIR_DOWN:  dir_rev = DIR_UP;
            default:   dir_rev = DIR_LEFT;
        endcase
    end

    // Bounds are tested on 11-bit copies so an out-of-range step can never wrap into range.
    always_comb begin
        move_ok = 1'b1;
        nx      = head_x;
        ny      = head_y;
        case (pend_q)
            DIR_RIGHT: if (hx_w + STEP_W > XMAX_W) move_ok = 1'b0; else nx = head_x + STEP10;
            DIR_LEFT:  if (hx_w < XMIN_W + STEP_W) move_ok = 1'b0; else nx = head_x - STEP10;
            DIR_DOWN:  if (hy_w + STEP_W > YMAX_W) move_ok = 1'b0; else ny = head_y + STEP10;
            DIR_UP:    if (hy_w < YMIN_W + STEP_W) move_ok = 1'b0; else ny = head_y - STEP10;
            default:   move_ok = 1'b0;
        endcase
    end

    assign dx  = (nx >= prey_x) ? (nx - prey_x) : (prey_x - nx);
    assign dy  = (ny >= prey_y) ? (ny - prey_y) : (prey_y - ny);
    assign hit = (dx < HEAD10) && (dy < HEAD10);

    // Prey grid: 8-pixel columns and 6-pixel rows from the low corner, always inside the field.
    assign ly         = {4'b0000, lfsr[11:6]};
    assign new_prey_x = XMIN10 + {1'b0, lfsr[5:0], 3'b000};
    assign new_prey_y = YMIN10 + (ly << 2) + (ly << 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            game_over <= 1'b0;
            head_x    <= 10'd320;
            head_y    <= 10'd240;
            prey_x    <= 10'd200;
            prey_y    <= 10'd300;
            score     <= 8'd0;
            dir_q     <= DIR_RIGHT;
            pend_q    <= DIR_RIGHT;
            frame_cnt <= 8'd0;
            lfsr      <= 16'hACE1;
            start_q   <= 1'b0;
            eat_due   <= 1'b0;
        end else begin
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            start_q <= btn_start;
            case (state_q)
                IDLE: begin
                    if (start_evt) begin
                        state_q   <= PLAY;
                        head_x    <= 10'd320;
                        head_y    <= 10'd240;
                        dir_q     <= DIR_RIGHT;
                        pend_q    <= DIR_RIGHT;
                        score     <= 8'd0;
                        frame_cnt <= 8'd0;
                        eat_due   <= 1'b0;
                    end
                end
                PLAY: begin
                    if (btn_one && btn_dir != dir_rev)
                        pend_q <= btn_dir;
                    if (eat_due) begin
                        score   <= (score == 8'hFF) ? score : score + 8'd1;
                        prey_x  <= new_prey_x;
                        prey_y  <= new_prey_y;
                        eat_due <= 1'b0;
                    end
                    if (frame_tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= 8'd0;
                            dir_q     <= pend_q;
                            if (move_ok) begin
                                head_x  <= nx;
                                head_y  <= ny;
                                eat_due <= hit;
                            end else begin
                                state_q   <= OVER;
                                game_over <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                OVER: begin
                    if (start_evt) begin
                        state_q   <= IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb/tb_snake_game_ctrl.sv - self-checking bench for snake_game_ctrl against a coordinate-level game model
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_up, btn_down, btn_left, btn_right, btn_start;
    logic [9:0] head_x, head_y, prey_x, prey_y;
    logic [7:0] score;
    logic [1:0] state;
    logic       game_over;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    snake_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start),
        .head_x(head_x), .head_y(head_y), .prey_x(prey_x), .prey_y(prey_y),
        .score(score), .state(state), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Game model: positions as signed ints, direction as a (dx,dy) unit vector.
    int m_state, m_hx, m_hy, m_px, m_py, m_score;
    int m_dx, m_dy, m_pdx, m_pdy, m_frames, m_lfsr, m_prev_start, m_eat;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_hx = 320; m_hy = 240; m_px = 200; m_py = 300; m_score = 0;
        m_dx = 1; m_dy = 0; m_pdx = 1; m_pdy = 0; m_frames = 0;
        m_lfsr = 'hACE1; m_prev_start = 0; m_eat = 0;
    endtask

    task automatic model_step();
        int ns, nhx, nhy, npx, npy, nsc, ndx, ndy, npdx, npdy, nfr, neat, tx, ty, bx, by, nb;
        bit start;
        ns = m_state; nhx = m_hx; nhy = m_hy; npx = m_px; npy = m_py; nsc = m_score;
        ndx = m_dx; ndy = m_dy; npdx = m_pdx; npdy = m_pdy; nfr = m_frames; neat = m_eat;
        start = btn_start && (m_prev_start == 0);
        nb = int'(btn_up) + int'(btn_down) + int'(btn_left) + int'(btn_right);
        if (m_state == 0) begin
            if (start) begin
                ns = 1; nhx = 320; nhy = 240; ndx = 1; ndy = 0; npdx = 1; npdy = 0;
                nsc = 0; nfr = 0; neat = 0;
            end
        end else if (m_state == 1) begin
            if (nb == 1) begin
                bx = int'(btn_right) - int'(btn_left);
                by = int'(btn_down) - int'(btn_up);
                if (!(bx == -m_dx && by == -m_dy)) begin npdx = bx; npdy = by; end
            end
            if (m_eat != 0) begin
                nsc = (m_score >= 255) ? 255 : m_score + 1;
                npx = 15 + 8 * (m_lfsr & 63);
                npy = 15 + 6 * ((m_lfsr >> 6) & 63);
                neat = 0;
            end
            if (frame_tick) begin
                if (m_frames + 1 == 6) begin
                    nfr = 0; ndx = m_pdx; ndy = m_pdy;
                    tx = m_hx + 10 * m_pdx;
                    ty = m_hy + 10 * m_pdy;
                    if (tx < 15 || tx > 620 || ty < 15 || ty > 455) ns = 2;
                    else begin
                        nhx = tx; nhy = ty;
                        neat = (iabs(tx - m_px) < 10 && iabs(ty - m_py) < 10) ? 1 : 0;
                    end
                end else nfr = m_frames + 1;
            end
        end else if (start) ns = 0;
        m_state = ns; m_hx = nhx; m_hy = nhy; m_px = npx; m_py = npy; m_score = nsc;
        m_dx = ndx; m_dy = ndy; m_pdx = npdx; m_pdy = npdy; m_frames = nfr; m_eat = neat;
        m_prev_start = int'(btn_start);
        m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1)) & 'hFFFF;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(state), m_state);
            check("game_over", int'(game_over), (m_state == 2) ? 1 : 0);
            check("head_x", int'(head_x), m_hx);
            check("head_y", int'(head_y), m_hy);
            check("prey_x", int'(prey_x), m_px);
            check("prey_y", int'(prey_y), m_py);
            check("score", int'(score), m_score);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
        cyc();
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        cyc();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic moves(input int n);
        for (int i = 0; i < n * 6; i++) tick();
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
        cyc();
    endtask

    localparam logic [3:0] B_UP = 4'b1000, B_DOWN = 4'b0100, B_LEFT = 4'b0010, B_RIGHT = 4'b0001;

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; btn_start = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (3) cyc();
        check("rst_state", int'(state), 0);
        check("rst_game_over", int'(game_over), 0);
        check("rst_head_x", int'(head_x), 320);
        check("rst_head_y", int'(head_y), 240);
        check("rst_prey_x", int'(prey_x), 200);
        check("rst_prey_y", int'(prey_y), 300);
        check("rst_score", int'(score), 0);
        rst_n = 1'b1;
        chk_en = 1;
        cyc();

        pulse_start();
        check("start_state", int'(state), 1);
        moves(1);
        check("first_move_x", int'(head_x), 330);
        check("first_move_y", int'(head_y), 240);

        press(B_LEFT);
        press(B_UP);
        moves(1);
        check("up_after_rev_x", int'(head_x), 330);
        check("up_after_rev_y", int'(head_y), 230);

        press(B_LEFT | B_RIGHT);
        moves(1);
        check("dual_btn_x", int'(head_x), 330);
        check("dual_btn_y", int'(head_y), 220);

        press(B_LEFT);
        moves(13);
        check("left_run_x", int'(head_x), 200);
        press(B_DOWN);
        moves(7);
        for (int i = 0; i < 5; i++) tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("eat_edge_x", int'(head_x), 200);
        check("eat_edge_y", int'(head_y), 300);
        check("eat_edge_score", int'(score), 0);
        cyc();
        check("eat_score", int'(score), 1);

        press(B_LEFT);
        moves(18);
        check("wall_x", int'(head_x), 20);
        moves(1);
        check("over_x", int'(head_x), 20);
        check("over_y", int'(head_y), 300);
        check("over_state", int'(state), 2);
        check("over_flag", int'(game_over), 1);
        moves(1);
        check("over_hold_x", int'(head_x), 20);

        btn_start = 1'b1;
        repeat (6) cyc();
        check("held_start_state", int'(state), 0);
        btn_start = 1'b0;
        cyc();

        btn_start = 1'b1;
        repeat (4) cyc();
        check("held_play_state", int'(state), 1);
        check("restart_head_x", int'(head_x), 320);
        check("restart_score", int'(score), 0);
        btn_start = 1'b0;
        press(B_UP);
        for (int i = 0; i < 5; i++) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_flag", int'(game_over), 0);
        check("async_head_x", int'(head_x), 320);
        check("async_head_y", int'(head_y), 240);
        check("async_prey_x", int'(prey_x), 200);
        check("async_prey_y", int'(prey_y), 300);
        check("async_score", int'(score), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        pulse_start();
        moves(1);
        check("post_reset_move_x", int'(head_x), 330);
        check("post_reset_move_y", int'(head_y), 240);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 10, pixels moved per head step.
REQ-002 SHALL have parameter MOVE_FRAMES, default 6, frames between head steps.
REQ-003 SHALL have parameter X_MIN, default 15, lowest legal head_x.
REQ-004 SHALL have parameter X_MAX, default 620, highest legal head_x.
REQ-005 SHALL have parameter Y_MIN, default 15, lowest legal head_y.
REQ-006 SHALL have parameter Y_MAX, default 455, highest legal head_y.
REQ-007 SHALL have parameter HEAD, default 10, head and prey square size in pixels.
REQ-008 SHALL have port clk, input, 1, pixel clock, the single clock.
REQ-009 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-010 SHALL have port frame_tick, input, 1, one-cycle pulse at start of vertical blanking.
REQ-011 SHALL have ports btn_up, btn_down, btn_left, btn_right, input, 1 each, synchronised level direction requests.
REQ-012 SHALL have port btn_start, input, 1, synchronised level start/restart button.
REQ-013 SHALL have ports head_x and head_y, output, 10 each, head top-left pixel.
REQ-014 SHALL have ports prey_x and prey_y, output, 10 each, prey top-left pixel.
REQ-015 SHALL have port score, output, 8, prey eaten count.
REQ-016 SHALL have port state, output, 2, FSM state: IDLE=0, PLAY=1, OVER=2.
REQ-017 SHALL have port game_over, output, 1, high exactly when state==OVER.

Function
REQ-018 Registered FSM with states IDLE, PLAY, OVER; all outputs SHALL be registered.
REQ-019 A start event SHALL be the btn_start rising edge, detected against a one-cycle delayed copy; a held button produces one event.
REQ-020 IDLE plus start event: next edge enters PLAY with head (320,240), direction RIGHT, pending direction RIGHT, score 0, frame counter 0.
REQ-021 OVER plus start event: next edge enters IDLE; all other registers hold.
REQ-022 In PLAY, one asserted direction button sets pending direction at that edge; reversal of current direction, or more than one button asserted, SHALL be ignored.
REQ-023 frame_tick outside PLAY SHALL be ignored; the frame counter holds at 0.
REQ-024 In PLAY, each frame_tick increments the frame counter; a tick with the counter at MOVE_FRAMES-1 is a move edge: counter clears to 0 and current direction takes pending direction.
REQ-025 A move edge SHALL use pending direction as registered before that edge; a button captured on the same edge applies at the next move.
REQ-026 Bounds SHALL be checked before the arithmetic, with no 10-bit wrap: left illegal if head_x < X_MIN+STEP; right illegal if head_x+STEP > X_MAX; up and down likewise on Y.
REQ-027 Legal move: head shifts by STEP on the move edge. Illegal move: head holds and state becomes OVER on that edge.
REQ-028 Eat condition: new head overlaps prey, |dx|<HEAD and |dy|<HEAD, both unsigned-safe. On eat, the edge after the move SHALL increment score (saturate at 255) and reload the prey.
REQ-029 A 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every clock while rst_n is high, including in IDLE and OVER.
REQ-030 Prey reload: prey_x = X_MIN + 8*lfsr[5:0]; prey_y = Y_MIN + 6*lfsr[11:6]. Results are always in bounds; no rejection loop.
REQ-031 head_x, head_y, prey_x, prey_y and score SHALL hold in IDLE and OVER.

Reset
REQ-032 rst_n low SHALL immediately set: state IDLE; game_over 0; head (320,240); prey (200,300); score 0; direction and pending direction RIGHT; frame counter 0; LFSR 16'hACE1; start-edge register 0.
REQ-033 Reset asserted mid-PLAY SHALL abort any move or eat in progress; no partial update is visible after release.

Verification
REQ-034 Reset, pulse btn_start, 6 frame_ticks, no buttons -> state=1, head (330,240) after the 6th tick.
REQ-035 In PLAY moving RIGHT, assert btn_left -> ignored. Assert btn_up -> next move gives head_y=230.
REQ-036 Force head to (20,240), direction LEFT, then a move edge -> head holds (20,240), state=2, game_over=1. Start event -> state=0.
REQ-037 Steer head onto prey (200,300) -> score=1 one cycle after the move edge; prey equals the formula applied to the current LFSR; score stops at 255 when forced.
REQ-038 btn_start held high through IDLE->PLAY -> only one transition; 5 ticks then reset low mid-frame -> all outputs at reset values asynchronously.
REQ-039 Two direction buttons asserted together -> pending direction unchanged.
